// File: rtl/com_csr_arb.sv
// com_csr_arb: N-master to 1-slave CSR arbiter using the valid/ready handshake
// (write, addr, wdata, wstrb, rdata).
//   - Round-robin arbitration in IDLE (one cycle latency), with the grant
//     locked until completion.
//   - A per-transaction timeout forces an error completion that returns
//     TO_RDATA. Writes that time out are dropped.
//   - If the granted master withdraws valid, the transaction is aborted.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m_csr_valid/write  [NM]         per-master request qualifiers
//   m_csr_addr/wdata/wstrb          packed per-master payload (master i at [i*W +: W])
//   m_csr_ready        [NM]         per-master completion
//   m_csr_rdata        [DW]         shared read data; valid only with the granted ready
//   s_csr_*                         single slave-side bundle
//   gnt_idx, busy                   current grant and GRANT-state flag
//   to_pulse, to_cnt                timeout completion pulse, saturating timeout count
module com_csr_arb #(
  parameter int          NM       = 2,
  parameter int          AW       = 16,
  parameter int          DW       = 32,
  parameter int          TO_CYC   = 1024,
  parameter logic [31:0] TO_RDATA = 32'hDEAD_BEEF,
  localparam int         SW       = DW / 8,
  localparam int         GW       = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM-1:0]    m_csr_valid,
  input  logic [NM-1:0]    m_csr_write,
  input  logic [NM*AW-1:0] m_csr_addr,
  input  logic [NM*DW-1:0] m_csr_wdata,
  input  logic [NM*SW-1:0] m_csr_wstrb,
  output logic [NM-1:0]    m_csr_ready,
  output logic [DW-1:0]    m_csr_rdata,
  output logic             s_csr_valid,
  output logic             s_csr_write,
  output logic [AW-1:0]    s_csr_addr,
  output logic [DW-1:0]    s_csr_wdata,
  output logic [SW-1:0]    s_csr_wstrb,
  input  logic             s_csr_ready,
  input  logic [DW-1:0]    s_csr_rdata,
  output logic [GW-1:0]    gnt_idx,
  output logic             busy,
  output logic             to_pulse,
  output logic [7:0]       to_cnt
);

  localparam int TW      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int TO_LAST = (TO_CYC > 0) ? TO_CYC - 1 : 0;
  localparam logic [DW-1:0] TO_RD = DW'(TO_RDATA);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gnt_q,   gnt_d;
  logic [GW-1:0] ptr_q,   ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    to_cnt_q, to_cnt_d;

  logic          in_grant;
  logic          gnt_valid;
  logic          complete;
  logic          timeout_hit;
  logic [GW-1:0] ptr_next;
  logic          found;
  logic [GW-1:0] pick;

  assign in_grant  = (state_q == GRANT);
  assign gnt_valid = in_grant && m_csr_valid[gnt_q];
  assign complete  = gnt_valid && s_csr_ready;
  // Slave ready in the last allowed cycle wins over the timeout.
  assign timeout_hit = (TO_CYC > 0) && gnt_valid && !s_csr_ready &&
                       (timer_q == TW'(TO_LAST));
  // Explicit wrap compare so non-power-of-two NM never lands on an unused index.
  assign ptr_next = (gnt_q == GW'(NM - 1)) ? '0 : gnt_q + 1'b1;

  // First requester at or after the round-robin pointer, wrapping NM-1 -> 0.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NM) idx = idx - NM;
      if (!found && m_csr_valid[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      timer_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (found) begin
          gnt_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Abort, normal completion and timeout all release the grant the same way.
        if (!gnt_valid || complete || timeout_hit) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
          timer_d = '0;
          if (timeout_hit && (to_cnt_q != 8'hFF)) to_cnt_d = to_cnt_q + 8'd1;
        end else if (TO_CYC > 0) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m_csr_ready = '0;
    m_csr_rdata = '0;
    s_csr_valid = 1'b0;
    s_csr_write = 1'b0;
    s_csr_addr  = '0;
    s_csr_wdata = '0;
    s_csr_wstrb = '0;
    to_pulse    = 1'b0;
    if (in_grant) begin
      s_csr_valid        = gnt_valid && !timeout_hit;
      s_csr_write        = m_csr_write[gnt_q];
      s_csr_addr         = m_csr_addr[32'(gnt_q)*AW +: AW];
      s_csr_wdata        = m_csr_wdata[32'(gnt_q)*DW +: DW];
      s_csr_wstrb        = m_csr_wstrb[32'(gnt_q)*SW +: SW];
      m_csr_ready[gnt_q] = complete || timeout_hit;
      m_csr_rdata        = timeout_hit ? TO_RD : s_csr_rdata;
      to_pulse           = timeout_hit;
    end
  end

  assign gnt_idx = gnt_q;
  assign busy    = in_grant;
  assign to_cnt  = to_cnt_q;

endmodule

// File: tb/tb_com_csr_arb.sv
module tb_com_csr_arb;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    m_csr_valid;
  logic [NM-1:0]    m_csr_write;
  logic [NM*AW-1:0] m_csr_addr;
  logic [NM*DW-1:0] m_csr_wdata;
  logic [NM*SW-1:0] m_csr_wstrb;
  logic [NM-1:0]    m_csr_ready;
  logic [DW-1:0]    m_csr_rdata;
  logic             s_csr_valid;
  logic             s_csr_write;
  logic [AW-1:0]    s_csr_addr;
  logic [DW-1:0]    s_csr_wdata;
  logic [SW-1:0]    s_csr_wstrb;
  logic             s_csr_ready;
  logic [DW-1:0]    s_csr_rdata;
  logic [1:0]       gnt_idx;
  logic             busy;
  logic             to_pulse;
  logic [7:0]       to_cnt;

  com_csr_arb #(.NM(NM), .AW(AW), .DW(DW), .TO_CYC(8), .TO_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_csr_valid(m_csr_valid), .m_csr_write(m_csr_write), .m_csr_addr(m_csr_addr),
    .m_csr_wdata(m_csr_wdata), .m_csr_wstrb(m_csr_wstrb), .m_csr_ready(m_csr_ready),
    .m_csr_rdata(m_csr_rdata),
    .s_csr_valid(s_csr_valid), .s_csr_write(s_csr_write), .s_csr_addr(s_csr_addr),
    .s_csr_wdata(s_csr_wdata), .s_csr_wstrb(s_csr_wstrb), .s_csr_ready(s_csr_ready),
    .s_csr_rdata(s_csr_rdata),
    .gnt_idx(gnt_idx), .busy(busy), .to_pulse(to_pulse), .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  // Slave model: ready after s_lat cycles of valid, rdata tagged with the address.
  logic s_en;
  int   s_lat;
  int   sv_cnt = 0;
  always @(posedge clk) begin
    if (!s_csr_valid || s_csr_ready) sv_cnt <= 0;
    else                             sv_cnt <= sv_cnt + 1;
  end
  assign s_csr_ready = s_en && (sv_cnt == s_lat);
  assign s_csr_rdata = {16'hC0DE, s_csr_addr};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_master(input int i, input logic v, input logic w, input logic [15:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    m_csr_valid[i]          = v;
    m_csr_write[i]          = w;
    m_csr_addr[i*AW +: AW]  = a;
    m_csr_wdata[i*DW +: DW] = d;
    m_csr_wstrb[i*SW +: SW] = s;
  endtask

  function automatic int idx_of(input logic [NM-1:0] v);
    int r = -1;
    for (int i = 0; i < NM; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int          m;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        sen;
    int          lat;
    int          exp_n;
    logic [31:0] exp_rdata;
    logic        exp_pulse;
    logic [7:0]  exp_cnt;
  } vec_t;

  // Single transaction from the current posedge+1 point; ends at posedge+1.
  task automatic run_txn(input int id, input vec_t v);
    int  n = 0;
    bit  done = 0;
    s_en  = v.sen;
    s_lat = v.lat;
    set_master(v.m, 1'b1, v.wr, v.addr, v.wdata, v.wstrb);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        chk($sformatf("v%0d_gnt", id), gnt_idx, v.m);
        chk($sformatf("v%0d_s_payload", id), {s_csr_valid, s_csr_write, s_csr_addr, s_csr_wstrb},
            {1'b1, v.wr, v.addr, v.wstrb});
        chk($sformatf("v%0d_s_wdata", id), s_csr_wdata, v.wdata);
      end
      if (m_csr_ready != '0) begin
        done = 1;
        chk($sformatf("v%0d_ready_onehot", id), m_csr_ready, 4'b0001 << v.m);
        chk($sformatf("v%0d_latency", id), n, v.exp_n);
        chk($sformatf("v%0d_rdata", id), m_csr_rdata, v.exp_rdata);
        chk($sformatf("v%0d_to_pulse", id), to_pulse, v.exp_pulse);
        chk($sformatf("v%0d_s_valid_ready", id), {s_csr_valid, s_csr_ready},
            {!v.exp_pulse, !v.exp_pulse});
      end
      @(posedge clk); #1;
    end
    if (!done) chk($sformatf("v%0d_no_ready", id), 0, 1);
    set_master(v.m, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk($sformatf("v%0d_pulse_after", id), to_pulse, 1'b0);
    chk($sformatf("v%0d_to_cnt", id), to_cnt, v.exp_cnt);
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc, last, hit, n;
    bit seen;
    logic [15:0] cur_addr[NM];
    int order_exp[5];
    int order_got[$];

    vecs[0] = '{2, 1'b1, 16'h0040, 32'h1234_5678, 4'b0011, 1'b1, 1, 3, 32'hC0DE_0040, 1'b0, 8'd0};
    vecs[1] = '{0, 1'b0, 16'h0008, 32'h0,         4'b0000, 1'b0, 1, 9, 32'hDEAD_BEEF, 1'b1, 8'd1};
    vecs[2] = '{3, 1'b0, 16'h0ABC, 32'h0,         4'b0000, 1'b1, 1, 3, 32'hC0DE_0ABC, 1'b0, 8'd1};
    vecs[3] = '{1, 1'b0, 16'h0077, 32'h0,         4'b0000, 1'b1, 7, 9, 32'hC0DE_0077, 1'b0, 8'd1};
    vecs[4] = '{0, 1'b1, 16'h0010, 32'hCAFE_F00D, 4'b1111, 1'b1, 8, 9, 32'hDEAD_BEEF, 1'b1, 8'd2};
    vecs[5] = '{2, 1'b0, 16'h1234, 32'h0,         4'b0000, 1'b1, 3, 5, 32'hC0DE_1234, 1'b0, 8'd2};
    order_exp = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    m_csr_valid = '0; m_csr_write = '0; m_csr_addr = '0; m_csr_wdata = '0; m_csr_wstrb = '0;
    s_en = 1'b0; s_lat = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", {m_csr_ready, s_csr_valid, busy, to_pulse, gnt_idx, to_cnt},
        {4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});
    chk("rst_rdata_addr", {m_csr_rdata, s_csr_addr}, 48'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-GRANT with master 1 active, then re-arbitration
    set_master(1, 1'b1, 1'b0, 16'h0011, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("t1_grant_before_rst", {busy, gnt_idx}, {1'b1, 2'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("t1_in_rst", {s_csr_valid, busy, gnt_idx, to_cnt, m_csr_ready}, {1'b0, 1'b0, 2'd0, 8'd0, 4'b0});
    @(posedge clk); #1;
    rst_n = 1'b1; s_en = 1'b1; s_lat = 1;
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk); n++;
      if (m_csr_ready != '0) begin
        seen = 1;
        chk("t1_ready", m_csr_ready, 4'b0010);
        chk("t1_gnt", gnt_idx, 2'd1);
        chk("t1_latency", n, 3);
        chk("t1_rdata", m_csr_rdata, 32'hC0DE_0011);
      end
      @(posedge clk); #1;
    end
    if (!seen) chk("t1_no_ready", 0, 1);
    set_master(1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    // Round robin with all four masters reading continuously
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NM; i++) begin
      cur_addr[i] = 16'h0100 + 16'(i);
      set_master(i, 1'b1, 1'b0, cur_addr[i], 32'h0, 4'h0);
    end
    cnt = 0; cyc = 0; last = 0;
    while (cnt < 5 && cyc < 60) begin
      @(negedge clk); cyc++; hit = -1;
      if (m_csr_ready != '0) begin
        hit = idx_of(m_csr_ready);
        chk($sformatf("rr%0d_order", cnt), hit, order_exp[cnt]);
        chk($sformatf("rr%0d_gnt", cnt), gnt_idx, order_exp[cnt]);
        chk($sformatf("rr%0d_rdata", cnt), m_csr_rdata, {16'hC0DE, cur_addr[hit]});
        if (cnt == 0) chk("rr_first_cycle", cyc, 3);
        else          chk($sformatf("rr%0d_spacing", cnt), cyc - last, 3);
        last = cyc;
        cnt++;
      end
      @(posedge clk); #1;
      if (hit >= 0) begin
        if (cnt < 5) begin
          cur_addr[hit] = cur_addr[hit] + 16'h0010;
          set_master(hit, 1'b1, 1'b0, cur_addr[hit], 32'h0, 4'h0);
        end else begin
          m_csr_valid = '0;
        end
      end
    end
    if (cnt < 5) chk("rr_incomplete", cnt, 5);

    // Directed single transactions (write, timeouts, last-cycle ready)
    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // Forced timeouts up to saturation
    s_en = 1'b0;
    for (int k = 0; k < 300; k++) begin
      set_master(k % NM, 1'b1, 1'b0, 16'(k), 32'h0, 4'h0);
      seen = 0; n = 0;
      while (!seen && n < 20) begin
        @(negedge clk); n++;
        if (m_csr_ready != '0) seen = 1;
        @(posedge clk); #1;
      end
      if (!seen) chk($sformatf("sat%0d_no_ready", k), 0, 1);
      set_master(k % NM, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      if (k == 251) begin
        @(negedge clk);
        chk("sat_to_cnt_254", to_cnt, 8'd254);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("sat_to_cnt_255", to_cnt, 8'd255);
    @(posedge clk); #1;

    // Master 1 drops valid mid-grant; master 2 must be next
    set_master(1, 1'b1, 1'b0, 16'h0500, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("ab_grant1", {busy, gnt_idx}, {1'b1, 2'd1});
    @(posedge clk); #1;
    set_master(0, 1'b1, 1'b0, 16'h0600, 32'h0, 4'h0);
    set_master(2, 1'b1, 1'b0, 16'h0602, 32'h0, 4'h0);
    @(negedge clk);
    chk("ab_locked", {busy, gnt_idx, m_csr_ready}, {1'b1, 2'd1, 4'b0});
    @(posedge clk); #1;
    set_master(1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("ab_drop_cycle", {s_csr_valid, m_csr_ready, to_pulse}, {1'b0, 4'b0, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_idle", {busy, m_csr_ready, to_pulse}, {1'b0, 4'b0, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_next_grant", {busy, gnt_idx, to_cnt}, {1'b1, 2'd2, 8'd255});
    @(posedge clk); #1;
    s_en = 1'b1; s_lat = 1;
    n = 0;
    while (order_got.size() < 2 && n < 20) begin
      @(negedge clk); n++; hit = -1;
      if (m_csr_ready != '0) begin
        hit = idx_of(m_csr_ready);
        order_got.push_back(hit);
      end
      @(posedge clk); #1;
      if (hit >= 0) set_master(hit, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    end
    if (order_got.size() == 2) begin
      chk("ab_serve_first", order_got[0], 2);
      chk("ab_serve_second", order_got[1], 0);
    end else begin
      chk("ab_drain_count", order_got.size(), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
